// File: rtl/tt_uart_pkg.sv
// ----------------------------------------------------------------------------
// tt_uart_pkg
// Shared types and constants for the tt_uart_tx transmitter.
//   uart_state_e : transmitter FSM states (IDLE, START, DATA, STOP)
//   DATA_BITS    : data bits per frame (8N1)
//   STOP_BITS    : stop bits per frame
// ----------------------------------------------------------------------------
package tt_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage

// File: rtl/tt_byte_fifo.sv
// ----------------------------------------------------------------------------
// tt_byte_fifo
// Synchronous byte FIFO with occupancy count.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (empties the FIFO)
//   push     : write data_in this cycle (ignored while full)
//   pop      : drop the head entry this cycle (ignored while empty)
//   data_in  : byte to write
//   data_out : head byte (valid while !empty)
//   count    : entries held, 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
// ----------------------------------------------------------------------------
module tt_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               data_in,
    output logic [7:0]               data_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    // A push while full is dropped even if a pop frees a slot this cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    // NOTE: the storage array has no reset; entries are only observable
    // through the pointers, which are reset, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (push_ok && !rst) mem_q[wr_ptr_q] <= data_in;
    end

    assign data_out = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/tt_uart_tx.sv
// ----------------------------------------------------------------------------
// tt_uart_tx
// 8N1 UART transmitter fed by a small byte FIFO. Frames are sent back to
// back while ena is high and bytes are queued.
// Ports:
//   clk        : sole clock, rising edge
//   rst        : synchronous active-high reset (aborts frame, empties FIFO)
//   ena        : permits new frames to start; never aborts a running frame
//   wr_data    : byte to queue
//   wr_valid   : wr_data offered this cycle
//   wr_ready   : FIFO can accept a byte this cycle
//   tx         : registered serial line, idle high
//   busy       : a frame is in progress
//   fifo_count : bytes held in the FIFO
// ----------------------------------------------------------------------------
module tt_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    import tt_uart_pkg::*;

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;

    logic             fifo_pop;
    logic [7:0]       fifo_data;
    logic             fifo_full, fifo_empty;
    logic             bit_end;

    tt_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (wr_valid),
        .pop      (fifo_pop),
        .data_in  (wr_data),
        .data_out (fifo_data),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign wr_ready = !fifo_full;
    assign bit_end  = (cnt_q == CNT_MAX);

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        tx_d      = tx_q;
        fifo_pop  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (ena && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_data;
                    state_d  = START;
                    tx_d     = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    tx_d      = shreg_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d   = STOP;
                        bit_idx_d = '0;
                        tx_d      = 1'b1;
                    end else begin
                        // LSB first: shift right and present the next bit.
                        bit_idx_d = bit_idx_q + 3'd1;
                        shreg_d   = shreg_q >> 1;
                        tx_d      = shreg_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit when possible.
                    if (ena && !fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_data;
                        state_d  = START;
                        tx_d     = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_tt_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_tt_uart_tx
// Self-checking bench for tt_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A frame-level model (byte queue + position within a 10-bit frame) predicts
// tx/busy/fifo_count/wr_ready every cycle; directed scenarios add literal
// expectations for bit patterns, run lengths and latencies.
// ----------------------------------------------------------------------------
module tb_tt_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    int errors = 0;
    int checks = 0;

    tt_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame-level model: queue of bytes, current byte, position in frame.
    // ------------------------------------------------------------------
    logic [7:0] mq[$];
    logic [7:0] m_cur = 8'h00;
    bit         m_active = 1'b0;
    int         m_t = 0;
    bit         m_valid = 1'b0;

    always @(posedge clk) begin : model
        bit start_ok;
        bit push_ok;
        if (rst) begin
            mq.delete();
            m_active = 1'b0;
            m_t      = 0;
            m_valid  = 1'b1;
        end else begin
            start_ok = ena && (mq.size() > 0) && (!m_active || m_t == FRAME - 1);
            push_ok  = wr_valid && (mq.size() < DEPTH);
            if (m_active) begin
                if (m_t == FRAME - 1) m_active = 1'b0;
                else                  m_t++;
            end
            if (start_ok) begin
                m_cur    = mq.pop_front();
                m_active = 1'b1;
                m_t      = 0;
            end
            if (push_ok) mq.push_back(wr_data);
        end
    end

    function automatic logic model_tx();
        int idx;
        if (!m_active) return 1'b1;
        idx = m_t / CPB;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return m_cur[idx-1];
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_tx",         tx,         model_tx());
            check("model_busy",       busy,       m_active);
            check("model_fifo_count", fifo_count, mq.size());
            check("model_wr_ready",   wr_ready,   mq.size() != DEPTH);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_data  = b;
        wr_valid = 1'b1;
        tick(1);
        wr_valid = 1'b0;
    endtask

    // Cycles busy stays high, starting from the next edge; ends on first idle.
    task automatic measure_busy(output int n);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            if (busy) n++;
            else if (n > 0) break;
        end
    endtask

    // Cycles tx holds lvl while busy, counting the current cycle.
    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (tx == lvl && busy && n < 1000) begin
            n++;
            tick(1);
        end
    endtask

    // Ticks until busy drops, bounded.
    task automatic wait_idle(input int max, output int n);
        n = 0;
        while (busy && n < max) begin
            n++;
            tick(1);
        end
        check("idle_timeout", n < max, 1);
    endtask

    logic [7:0] fill_bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int         n;
        logic [9:0] seq;

        // Reset state
        rst = 1'b1;
        tick(2);
        check("reset_tx",       tx,         1);
        check("reset_busy",     busy,       0);
        check("reset_count",    fifo_count, 0);
        check("reset_wr_ready", wr_ready,   1);
        rst = 1'b0;
        ena = 1'b1;
        tick(2);

        // Single byte 0xA5: start, 1,0,1,0,0,1,0,1, stop
        write_byte(8'hA5);
        seq = 10'b1101001010;
        check("a5_pre_start_tx", tx, 1);
        n = 0;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < CPB; c++) begin
                tick(1);
                check($sformatf("a5_bit%0d", b), tx, seq[b]);
                if (busy) n++;
            end
        end
        check("a5_busy_cycles", n, 40);
        tick(1);
        check("a5_end_busy", busy, 0);
        check("a5_end_tx",   tx,   1);

        // Fill with ena low: 4 accepted, 5th dropped, then 4 gapless frames
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_data  = fill_bytes[i];
            wr_valid = 1'b1;
            tick(1);
        end
        wr_valid = 1'b0;
        check("fill_count",    fifo_count, 4);
        check("fill_wr_ready", wr_ready,   0);
        check("fill_busy",     busy,       0);
        ena = 1'b1;
        measure_busy(n);
        check("fill_busy_cycles", n,          160);
        check("fill_end_tx",      tx,         1);
        check("fill_end_count",   fifo_count, 0);

        // Extremes: 0x00 then 0xFF back to back
        ena = 1'b0;
        write_byte(8'h00);
        write_byte(8'hFF);
        ena = 1'b1;
        tick(1);
        run_len(1'b0, n); check("x00_low_run",   n, 36);
        run_len(1'b1, n); check("x00_stop_run",  n, 4);
        run_len(1'b0, n); check("xff_start_run", n, 4);
        run_len(1'b1, n); check("xff_high_run",  n, 36);
        check("extreme_end_busy", busy, 0);
        check("extreme_end_tx",   tx,   1);

        // Reset mid-frame (inside a low data bit) with one byte still queued
        ena = 1'b0;
        write_byte(8'h00);
        write_byte(8'h96);
        ena = 1'b1;
        tick(1);
        check("rst_frame_started", busy, 1);
        tick(9);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_tx",       tx,         1);
        check("rst_busy",     busy,       0);
        check("rst_count",    fifo_count, 0);
        check("rst_wr_ready", wr_ready,   1);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (busy) n++;
        end
        check("rst_no_frames", n, 0);

        // Enable dropped mid-frame: frame completes, queued byte waits
        ena = 1'b0;
        write_byte(8'hC3);
        write_byte(8'h3C);
        ena = 1'b1;
        tick(1);
        check("drop_start_tx", tx, 0);
        tick(5);
        ena = 1'b0;
        wait_idle(100, n);
        check("drop_frame_rest", n,          35);
        check("drop_count",      fifo_count, 1);
        check("drop_idle_tx",    tx,         1);
        tick(3);
        check("drop_held_busy", busy, 0);
        ena = 1'b1;
        tick(1);
        check("drop_resume_tx",    tx,         0);
        check("drop_resume_busy",  busy,       1);
        check("drop_resume_count", fifo_count, 0);
        wait_idle(100, n);

        // Push on the last stop cycle while one byte is queued
        ena = 1'b0;
        write_byte(8'hE7);
        write_byte(8'h18);
        ena = 1'b1;
        tick(1);
        check("conc_count_after_pop", fifo_count, 1);
        tick(39);
        check("conc_last_stop_tx", tx, 1);
        wr_data  = 8'h81;
        wr_valid = 1'b1;
        tick(1);
        wr_valid = 1'b0;
        check("conc_count", fifo_count, 1);
        check("conc_tx",    tx,         0);
        check("conc_busy",  busy,       1);
        wait_idle(200, n);
        check("conc_drain", n, 80);

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
